// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared constants and enums for compare_tally
package cmp_pkg;

  localparam int DEFAULT_WIDTH  = 20;
  localparam int DEFAULT_WINDOW = 16;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    WIN_TIE = 2'b00,
    WIN_A   = 2'b01,
    WIN_B   = 2'b10
  } winner_t;

endpackage

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational A/B magnitude compare; signed when CMP_SIGNED_EN is defined
module cmp_core #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  always_comb begin
    eq = (a == b);
`ifdef CMP_SIGNED_EN
    gt = ($signed(a) > $signed(b));
    lt = ($signed(a) < $signed(b));
`else
    gt = (a > b);
    lt = (a < b);
`endif
  end

endmodule

// File: rtl/compare_tally.sv
// rtl/compare_tally.sv - registered pair compare with per-window outcome tally and summary handshake
// Optional signed compare selected by CMP_SIGNED_EN (see cmp_core).
module compare_tally
  import cmp_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int WINDOW = DEFAULT_WINDOW,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             res_valid,
  output logic             Same,
  output logic             A_High,
  output logic             B_High,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] same_cnt,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [1:0]       winner
);

  state_t state_q, state_d;

  logic             res_valid_q, res_valid_d;
  logic             same_q, same_d;
  logic             a_high_q, a_high_d;
  logic             b_high_q, b_high_d;
  logic [CNT_W-1:0] same_cnt_q, same_cnt_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;

  logic accept;
  logic window_done;
  logic cmp_eq, cmp_gt, cmp_lt;

  cmp_core #(
    .WIDTH(WIDTH)
  ) u_cmp_core (
    .a (A),
    .b (B),
    .eq(cmp_eq),
    .gt(cmp_gt),
    .lt(cmp_lt)
  );

  assign accept      = in_valid && in_ready;
  assign window_done = accept && (pair_cnt_q == CNT_W'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (window_done) state_d = REPORT;
      REPORT:  if (sum_ready)   state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // winner is only meaningful in REPORT; forced to tie elsewhere so reset reads 0
  always_comb begin
    in_ready  = (state_q == ACCUM);
    sum_valid = (state_q == REPORT);
    winner    = WIN_TIE;
    if (state_q == REPORT) begin
      if (a_cnt_q > b_cnt_q) begin
        winner = WIN_A;
      end else if (b_cnt_q > a_cnt_q) begin
        winner = WIN_B;
      end
    end
  end

  always_comb begin
    res_valid_d = accept;
    same_d      = same_q;
    a_high_d    = a_high_q;
    b_high_d    = b_high_q;
    same_cnt_d  = same_cnt_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    pair_cnt_d  = pair_cnt_q;

    if (accept) begin
      same_d     = cmp_eq;
      a_high_d   = cmp_gt;
      b_high_d   = cmp_lt;
      pair_cnt_d = pair_cnt_q + CNT_W'(1);
      if (cmp_eq) begin
        same_cnt_d = same_cnt_q + CNT_W'(1);
      end else if (cmp_gt) begin
        a_cnt_d = a_cnt_q + CNT_W'(1);
      end else begin
        b_cnt_d = b_cnt_q + CNT_W'(1);
      end
    end

    // Summary consumed: start a fresh window
    if ((state_q == REPORT) && sum_ready) begin
      same_cnt_d = '0;
      a_cnt_d    = '0;
      b_cnt_d    = '0;
      pair_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      same_q      <= 1'b0;
      a_high_q    <= 1'b0;
      b_high_q    <= 1'b0;
      same_cnt_q  <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      pair_cnt_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      same_q      <= same_d;
      a_high_q    <= a_high_d;
      b_high_q    <= b_high_d;
      same_cnt_q  <= same_cnt_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      pair_cnt_q  <= pair_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign Same      = same_q;
  assign A_High    = a_high_q;
  assign B_High    = b_high_q;
  assign same_cnt  = same_cnt_q;
  assign a_cnt     = a_cnt_q;
  assign b_cnt     = b_cnt_q;

endmodule

// File: tb/tb_compare_tally.sv
// tb/tb_compare_tally.sv - randomized self-checking bench for compare_tally against a queue-based window model
module tb_compare_tally;

  localparam int WIDTH  = 20;
  localparam int WINDOW = 4;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             res_valid;
  logic             Same;
  logic             A_High;
  logic             B_High;
  logic             sum_valid;
  logic             sum_ready = 1'b0;
  logic [CNT_W-1:0] same_cnt;
  logic [CNT_W-1:0] a_cnt;
  logic [CNT_W-1:0] b_cnt;
  logic [1:0]       winner;

  always #5 clk = ~clk;

  compare_tally #(
    .WIDTH (WIDTH),
    .WINDOW(WINDOW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .res_valid(res_valid),
    .Same     (Same),
    .A_High   (A_High),
    .B_High   (B_High),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .same_cnt (same_cnt),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt),
    .winner   (winner)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the outcomes of the current window (0 same, 1 A high, 2 B high)
  int win_q[$];
  bit m_res_valid = 0;
  bit m_same = 0;
  bit m_ahigh = 0;
  bit m_bhigh = 0;
  bit checking = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int outcome(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    int sa;
    int sb;
`ifdef CMP_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'({12'd0, a});
    sb = int'({12'd0, b});
`endif
    if (sa == sb) return 0;
    if (sa > sb)  return 1;
    return 2;
  endfunction

  function automatic int count_of(int k);
    int n = 0;
    foreach (win_q[i]) if (win_q[i] == k) n++;
    return n;
  endfunction

  function automatic bit m_report();
    return win_q.size() == WINDOW;
  endfunction

  function automatic int m_winner();
    if (!m_report()) return 0;
    if (count_of(1) > count_of(2)) return 1;
    if (count_of(2) > count_of(1)) return 2;
    return 0;
  endfunction

  task automatic model_step(bit r, bit iv, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit sr);
    int o;
    if (r) begin
      win_q.delete();
      m_res_valid = 0;
      m_same = 0;
      m_ahigh = 0;
      m_bhigh = 0;
    end else if (m_report()) begin
      m_res_valid = 0;
      if (sr) win_q.delete();
    end else if (iv) begin
      o = outcome(a, b);
      win_q.push_back(o);
      m_res_valid = 1;
      m_same  = (o == 0);
      m_ahigh = (o == 1);
      m_bhigh = (o == 2);
    end else begin
      m_res_valid = 0;
    end
  endtask

  task automatic cycle(bit r, bit iv, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit sr);
    rst = r;
    in_valid = iv;
    A = a;
    B = b;
    sum_ready = sr;
    @(posedge clk);
    #1;
    model_step(r, iv, a, b, sr);
    checking = 1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready",  int'(in_ready),  int'(!m_report()));
      chk("sum_valid", int'(sum_valid), int'(m_report()));
      chk("res_valid", int'(res_valid), int'(m_res_valid));
      chk("Same",      int'(Same),      int'(m_same));
      chk("A_High",    int'(A_High),    int'(m_ahigh));
      chk("B_High",    int'(B_High),    int'(m_bhigh));
      chk("same_cnt",  int'(same_cnt),  count_of(0));
      chk("a_cnt",     int'(a_cnt),     count_of(1));
      chk("b_cnt",     int'(b_cnt),     count_of(2));
      chk("winner",    int'(winner),    m_winner());
    end
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int exp_a;
    int exp_b;
    int exp_w;

    // Reset: two cycles high
    cycle(1, 0, '0, '0, 0);
    cycle(1, 1, 20'd5, 20'd1, 0);
    chk("lit_reset_in_ready", int'(in_ready), 1);
    chk("lit_reset_res_valid", int'(res_valid), 0);
    chk("lit_reset_flags", int'({Same, A_High, B_High}), 0);
    chk("lit_reset_cnts", int'({same_cnt, a_cnt, b_cnt}), 0);
    chk("lit_reset_sum", int'({sum_valid, winner}), 0);

    // Single tie pair
    cycle(0, 1, 20'd3, 20'd3, 0);
    chk("lit_single_res_valid", int'(res_valid), 1);
    chk("lit_single_flags", int'({Same, A_High, B_High}), 3'b100);
    chk("lit_single_same_cnt", int'(same_cnt), 1);
    cycle(0, 0, '0, '0, 0);
    chk("lit_single_pulse", int'(res_valid), 0);
    chk("lit_single_hold", int'(Same), 1);
    cycle(1, 0, '0, '0, 0);

    // Full window, summary held
    cycle(0, 1, 20'hFFFFF, 20'h0, 0);
    cycle(0, 1, 20'd1, 20'd2, 0);
    cycle(0, 1, 20'd5, 20'd4, 0);
    cycle(0, 1, 20'd7, 20'd7, 0);
`ifdef CMP_SIGNED_EN
    exp_a = 1; exp_b = 2; exp_w = 2;
`else
    exp_a = 2; exp_b = 1; exp_w = 1;
`endif
    for (int i = 0; i < 3; i++) begin
      chk("lit_win_a_cnt", int'(a_cnt), exp_a);
      chk("lit_win_b_cnt", int'(b_cnt), exp_b);
      chk("lit_win_same_cnt", int'(same_cnt), 1);
      chk("lit_win_winner", int'(winner), exp_w);
      chk("lit_win_in_ready", int'(in_ready), 0);
      chk("lit_win_sum_valid", int'(sum_valid), 1);
      if (i < 2) cycle(0, 0, '0, '0, 0);
    end
    cycle(0, 0, '0, '0, 1);
    chk("lit_win_cleared", int'({same_cnt, a_cnt, b_cnt}), 0);
    chk("lit_win_in_ready_back", int'(in_ready), 1);

    // Signed vs unsigned boundary
    cycle(0, 1, 20'h80000, 20'h00001, 0);
`ifdef CMP_SIGNED_EN
    chk("lit_signed_B_High", int'(B_High), 1);
`else
    chk("lit_unsigned_A_High", int'(A_High), 1);
`endif
    cycle(1, 0, '0, '0, 0);

    // Reset mid-window, then a window of ties
    cycle(0, 1, 20'd9, 20'd1, 0);
    cycle(0, 1, 20'd1, 20'd9, 0);
    cycle(1, 1, 20'd4, 20'd2, 0);
    chk("lit_midrst_cnts", int'({same_cnt, a_cnt, b_cnt}), 0);
    for (int i = 0; i < WINDOW; i++) cycle(0, 1, 20'(i * 11), 20'(i * 11), 0);
    chk("lit_ties_same_cnt", int'(same_cnt), 4);
    chk("lit_ties_winner", int'(winner), 0);
    cycle(0, 0, '0, '0, 1);

    // in_valid held through REPORT
    for (int i = 0; i < WINDOW; i++) cycle(0, 1, 20'd2, 20'd6, 0);
    cycle(0, 1, 20'd9, 20'd2, 0);
    cycle(0, 1, 20'd9, 20'd2, 0);
    chk("lit_hold_b_cnt", int'(b_cnt), 4);
    cycle(0, 1, 20'd9, 20'd2, 1);
    chk("lit_hold_cleared", int'({same_cnt, a_cnt, b_cnt}), 0);
    cycle(0, 1, 20'd9, 20'd2, 0);
    chk("lit_hold_a_cnt", int'(a_cnt), 1);
    chk("lit_hold_other", int'({same_cnt, b_cnt}), 0);
    cycle(1, 0, '0, '0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = 20'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = 20'($urandom_range(0, 7));
        default: rb = 20'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) ra = 20'($urandom_range(0, 7));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, ra, rb,
            $urandom_range(0, 1) == 1);
    end

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
